flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Shares the single 16-entry x 256-bit flash RAM port between two requesters.
- Port 0 is the password engine (Top_level datapath); port 1 is the host/loader side (account provisioning, readback).
- Serialises single-beat read/write transactions with round-robin fairness.
- Bounds-checks addresses against max_address and returns per-port acknowledge, read data and error.

Parameters:
ADDR_W, 4, flash address width
DATA_W, 256, flash word width (account 128 + encrypted password 128)
RR_INIT, 0, port favoured by round-robin after reset (0 or 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
max_address  in  ADDR_W  highest valid flash address, inclusive; sampled at acceptance
req0  in  1  port 0 request; held high until ack0 or err0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 transaction complete, 1-cycle pulse
err0  out  1  port 0 address out of range, 1-cycle pulse
rdata0  out  DATA_W  port 0 read data; valid with ack0 on reads; held until next port 0 read
req1, we1, addr1, wdata1, ack1, err1, rdata1  as port 0, for port 1
mem_addr  out  ADDR_W  to RAM addr
mem_we  out  1  to RAM we
mem_wdata  out  DATA_W  to RAM data
mem_q  in  DATA_W  from RAM q; synchronous read, valid the cycle after mem_addr is presented
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset values: ack*/err*/mem_we/busy = 0; mem_addr = 0; mem_wdata = 0; rdata0/rdata1 = 0. The round-robin pointer resets to favour RR_INIT.
- FSM states: IDLE, ISSUE, RWAIT, DONE.
- IDLE:
  - With a single request, that port wins.
  - With both requesting, the favoured port wins.
  - At acceptance, latch port id, we, addr and wdata; the requester's inputs are don't-care afterwards.
  - If latched addr > max_address: go to DONE with the error flag set; no RAM access occurs.
  - Otherwise go to ISSUE.
- ISSUE: drive mem_addr and mem_wdata, and mem_we = latched we, for exactly one cycle. Writes go to DONE; reads go to RWAIT.
- RWAIT: mem_we = 0. Capture mem_q into the winner's rdata register at the end of this cycle, then go to DONE.
- DONE:
  - Pulse ack (or err) of the winning port for exactly this cycle.
  - The round-robin pointer flips to favour the other port.
  - Go to IDLE.
- Latency, counting the acceptance cycle in IDLE as cycle 0:
  - Write: ack at cycle 2.
  - Read: ack at cycle 3, with rdata valid.
  - Error: err at cycle 1.
  - Back-to-back minimum: 4 cycles per write, 5 cycles per read.
- Handshake: a requester drops req on the edge after it samples ack/err. A req still high in the cycle after DONE is a new request.
- mem_we is high only in ISSUE for a write. mem_addr and mem_wdata hold their last values otherwise.
- Simultaneous requests alternate strictly: with both continuously requesting, grants go 0,1,0,1… (RR_INIT = 0).
- A request arriving while busy waits; it is never dropped.
- A port's rdata register changes only on that port's completed read, never on a write or an error.
- max_address = 15 permits every address. max_address = 0 permits only address 0.
- Reset in any state returns to IDLE within the same edge. An in-flight write is not issued unless ISSUE had already completed. No ack/err follows a reset.

Test Plan:
- Reset, port 0 write addr 3, data {128'haaaa…aa, 128'hf256847daaa39da5d870adf569712360}, max_address 15 -> mem_we high 1 cycle at cycle 1 with mem_addr 3; ack0 at cycle 2; busy low at cycle 3.
- Port 1 read addr 3 after the above -> ack1 at cycle 3; rdata1 equals the written word; rdata0 unchanged (0).
- req0 and req1 both asserted in the same cycle, continuously re-requesting reads -> grant order 0,1,0,1 with RR_INIT = 0; no port waits more than one transaction.
- max_address 2, port 1 read addr 5 -> err1 at cycle 1; no ack1; mem_we stays 0; rdata1 unchanged. Addr 2 is accepted normally.
- rst asserted during ISSUE of a port 0 write -> next cycle state IDLE, busy 0, mem_we 0, no ack0. The RAM location is not written only if rst coincided with the ISSUE edge.
- Port 0 write to addr 7 immediately followed by a port 1 read of addr 7 -> read returns the new data; no overlap of mem_we with the read ISSUE.

Source files
------------

// File: rtl/flash_arbiter_if.sv
// Bus bundle between the flash arbiter, its two requesters and the flash RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface flash_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 256
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_q,
    output ack0, err0, rdata0,
    output ack1, err1, rdata1,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_q,
    input  ack0, err0, rdata0,
    input  ack1, err1, rdata1,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 16x256 flash RAM.
// Serialises single-beat reads/writes, bounds-checks addresses, all outputs registered.
module flash_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 256,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] max_address,
  output logic              busy,
  flash_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_e;

  state_e            state_q;
  logic              port_q;
  logic              we_q;
  logic              rr_q;
  logic              busy_q;
  logic              ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              grant_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  // rr_q names the port that wins a tie
  always_comb begin
    grant_d = 1'b0;
    if (bus.req0 && bus.req1) grant_d = rr_q;
    else if (bus.req1)        grant_d = 1'b1;
    sel_we_d    = grant_d ? bus.we1    : bus.we0;
    sel_addr_d  = grant_d ? bus.addr1  : bus.addr0;
    sel_wdata_d = grant_d ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      rr_q        <= 1'(RR_INIT);
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            port_q <= grant_d;
            we_q   <= sel_we_d;
            busy_q <= 1'b1;
            if (sel_addr_d > max_address) begin
              // out-of-range: report without touching the RAM
              state_q <= DONE;
              if (grant_d) err1_q <= 1'b1;
              else         err0_q <= 1'b1;
            end else begin
              state_q     <= ISSUE;
              mem_addr_q  <= sel_addr_d;
              mem_wdata_q <= sel_wdata_d;
              mem_we_q    <= sel_we_d;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q <= DONE;
            if (port_q) ack1_q <= 1'b1;
            else        ack0_q <= 1'b1;
          end else begin
            state_q <= RWAIT;
          end
        end
        RWAIT: begin
          state_q <= DONE;
          if (port_q) begin
            rdata1_q <= bus.mem_q;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= bus.mem_q;
            ack0_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rr_q    <= ~port_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: vector table of single transactions against a
// behavioural flash RAM, plus sequences for arbitration order and reset.
module tb_flash_arbiter;

  localparam logic [255:0] W1 = {{16{8'haa}}, 128'hf256847daaa39da5d870adf569712360};
  localparam logic [255:0] W2 = {8{32'h12345678}};
  localparam logic [255:0] W3 = {4{64'hdeadbeef0badf00d}};
  localparam logic [255:0] W4 = {32{8'h5a}};
  localparam logic [255:0] W5 = {2{128'h0123456789abcdeffedcba9876543210}};
  localparam logic [255:0] W6 = {16{16'hc3c3}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] max_address = 4'd15;
  logic       busy;
  logic       ram_clr = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [255:0] rd_exp [2];
  logic [255:0] ram [16];

  flash_arbiter_if #(.ADDR_W(4), .DATA_W(256)) bus ();

  flash_arbiter #(.ADDR_W(4), .DATA_W(256), .RR_INIT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .max_address (max_address),
    .busy        (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read flash RAM model
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_q <= ram[bus.mem_addr];
  end

  typedef struct {
    logic         port;
    logic         we;
    logic [3:0]   addr;
    logic [255:0] wdata;
    logic [3:0]   maxa;
    logic         exp_err;
    logic [255:0] exp_rd;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    rd_exp[0] = '0;
    rd_exp[1] = '0;
  endtask

  task automatic txn(input vec_t v, input int idx);
    int   lat;
    int   we_cnt;
    logic got_err;
    logic other;
    logic done;
    lat = 0; we_cnt = 0; got_err = 1'b0; other = 1'b0; done = 1'b0;
    max_address = v.maxa;
    if (v.port) begin
      bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata; bus.req1 = 1'b1;
    end else begin
      bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata; bus.req0 = 1'b1;
    end
    for (int n = 1; n <= 8 && !done; n++) begin
      tick();
      if (bus.mem_we) we_cnt++;
      if (n == 1 && !v.exp_err && v.we) chk($sformatf("v%0d mem_addr", idx), 256'(bus.mem_addr), 256'(v.addr));
      if (v.port ? (bus.ack0 | bus.err0) : (bus.ack1 | bus.err1)) other = 1'b1;
      if (v.port ? (bus.ack1 | bus.err1) : (bus.ack0 | bus.err0)) begin
        lat = n;
        got_err = v.port ? bus.err1 : bus.err0;
        done = 1'b1;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (!v.we && !v.exp_err) rd_exp[v.port] = v.exp_rd;
    chk($sformatf("v%0d latency", idx), 256'(lat), 256'(v.exp_err ? 1 : (v.we ? 2 : 3)));
    chk($sformatf("v%0d err", idx), 256'(got_err), 256'(v.exp_err));
    chk($sformatf("v%0d mem_we cycles", idx), 256'(we_cnt), 256'(v.we && !v.exp_err));
    chk($sformatf("v%0d other port quiet", idx), 256'(other), 256'(0));
    chk($sformatf("v%0d rdata0", idx), bus.rdata0, rd_exp[0]);
    chk($sformatf("v%0d rdata1", idx), bus.rdata1, rd_exp[1]);
    tick();
    chk($sformatf("v%0d busy after", idx), 256'(busy), 256'(0));
  endtask

  initial begin
    int   order [4];
    int   g;
    logic seen;

    tv[0]  = '{1'b0, 1'b1, 4'd3,  W1,   4'd15, 1'b0, '0};
    tv[1]  = '{1'b1, 1'b0, 4'd3,  '0,   4'd15, 1'b0, W1};
    tv[2]  = '{1'b1, 1'b0, 4'd5,  '0,   4'd2,  1'b1, '0};
    tv[3]  = '{1'b1, 1'b0, 4'd2,  '0,   4'd2,  1'b0, '0};
    tv[4]  = '{1'b1, 1'b1, 4'd2,  W2,   4'd2,  1'b0, '0};
    tv[5]  = '{1'b1, 1'b0, 4'd2,  '0,   4'd2,  1'b0, W2};
    tv[6]  = '{1'b0, 1'b1, 4'd7,  W3,   4'd15, 1'b0, '0};
    tv[7]  = '{1'b1, 1'b0, 4'd7,  '0,   4'd15, 1'b0, W3};
    tv[8]  = '{1'b0, 1'b1, 4'd0,  W4,   4'd0,  1'b0, '0};
    tv[9]  = '{1'b0, 1'b0, 4'd1,  '0,   4'd0,  1'b1, '0};
    tv[10] = '{1'b0, 1'b0, 4'd0,  '0,   4'd0,  1'b0, W4};
    tv[11] = '{1'b1, 1'b1, 4'd15, W5,   4'd15, 1'b0, '0};
    tv[12] = '{1'b0, 1'b0, 4'd15, '0,   4'd15, 1'b0, W5};

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    tick();
    ram_clr = 1'b0;
    do_reset();

    chk("rst ack0", 256'(bus.ack0), 256'(0));
    chk("rst ack1", 256'(bus.ack1), 256'(0));
    chk("rst err0", 256'(bus.err0), 256'(0));
    chk("rst err1", 256'(bus.err1), 256'(0));
    chk("rst mem_we", 256'(bus.mem_we), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst mem_addr", 256'(bus.mem_addr), 256'(0));
    chk("rst mem_wdata", bus.mem_wdata, '0);
    chk("rst rdata0", bus.rdata0, '0);
    chk("rst rdata1", bus.rdata1, '0);

    for (int i = 0; i < 13; i++) txn(tv[i], i);

    // Both ports keep re-requesting reads; grants must alternate from port 0
    do_reset();
    max_address = 4'd15;
    bus.we0 = 1'b0; bus.addr0 = 4'd7;
    bus.we1 = 1'b0; bus.addr1 = 4'd15;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    g = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      tick();
      if (!bus.req0) bus.req0 = 1'b1;
      if (!bus.req1) bus.req1 = 1'b1;
      if (bus.ack0 && g < 4) begin order[g] = 0; g++; bus.req0 = 1'b0; end
      if (bus.ack1 && g < 4) begin order[g] = 1; g++; bus.req1 = 1'b0; end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("rr grant count", 256'(g), 256'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < g) chk($sformatf("rr grant %0d", k), 256'(order[k]), 256'(k % 2));
    end
    chk("rr rdata0", bus.rdata0, W3);
    chk("rr rdata1", bus.rdata1, W5);
    tick(); tick();

    // Reset while the write is in ISSUE: no ack, machine idle on the next cycle
    do_reset();
    bus.we0 = 1'b1; bus.addr0 = 4'd9; bus.wdata0 = W6; bus.req0 = 1'b1;
    tick();
    chk("issue mem_we", 256'(bus.mem_we), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b0;
    chk("issue-rst busy", 256'(busy), 256'(0));
    chk("issue-rst mem_we", 256'(bus.mem_we), 256'(0));
    chk("issue-rst ack0", 256'(bus.ack0), 256'(0));
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.ack0 | bus.err0 | bus.mem_we | busy) seen = 1'b1;
    end
    chk("issue-rst quiet", 256'(seen), 256'(0));

    // Reset on the acceptance edge: the write must never reach the RAM
    bus.we0 = 1'b1; bus.addr0 = 4'd10; bus.wdata0 = W6; bus.req0 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.ack0 | bus.mem_we | busy) seen = 1'b1;
      tick();
    end
    chk("accept-rst quiet", 256'(seen), 256'(0));
    rd_exp[0] = '0;
    rd_exp[1] = '0;
    txn('{1'b1, 1'b0, 4'd10, '0, 4'd15, 1'b0, '0}, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
